// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS unified-memory port arbiter.
// Included first so the arbiter and its timeout counter agree on encodings.
package mem_arb_pkg;

    typedef enum logic {IDLE, WAIT} arb_state_e;
    typedef enum logic {OWN_IF, OWN_LS} arb_owner_e;

    localparam logic [3:0] BE_WORD = 4'hF;
    localparam int unsigned TO_W = 16;

endpackage

// File: rtl/arb_timeout_cnt.sv
// 16-bit clear/enable cycle counter with a terminal-count compare.
// Used to bound how long the arbiter waits for a memory ack.
module arb_timeout_cnt
    import mem_arb_pkg::*;
#(
    parameter logic [TO_W-1:0] TERM = '0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tc = (cnt_q == TERM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and LS onto one single-ported memory with a
// valid/grant/response handshake, starvation guard and bus timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_ls_req,
    input  logic        i_ls_we,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_be,
    output logic        o_ls_gnt,
    output logic        o_ls_rvalid,
    output logic [31:0] o_ls_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_err
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [TO_W-1:0] TO_TERM =
        (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    arb_state_e  state_q, state_d;
    arb_owner_e  owner_q, owner_d;
    logic [3:0]  starve_q, starve_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        ls_rvalid_q, ls_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        err_q, err_d;

    logic        idle, waiting, force_if;
    logic        if_win, ls_win;
    logic        to_tc, to_hit, done;
    logic [31:0] rsp_data;

    assign idle     = (state_q == IDLE);
    assign waiting  = (state_q == WAIT);
    assign force_if = i_if_req && (starve_q == STARVE_LIM);

    // Grants are gated by reset so every output reads 0 while held.
    assign ls_win = i_rst_n && idle && i_ls_req && !force_if;
    assign if_win = i_rst_n && idle && i_if_req && !ls_win;

    assign to_hit = (TIMEOUT != 0) && to_tc;
    assign done   = waiting && (i_mem_ack || to_hit);

    // Ack wins over a same-cycle timeout; stores return 0.
    assign rsp_data = (i_mem_ack && !mem_we_q) ? i_mem_rdata : 32'h0;

    arb_timeout_cnt #(
        .TERM (TO_TERM)
    ) u_to_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (!waiting || done),
        .i_en    (waiting),
        .o_tc    (to_tc)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        err_d       = 1'b0;

        starve_d = starve_q;
        if (!i_if_req || if_win) begin
            starve_d = '0;
        end else if (ls_win && starve_q < STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (if_win || ls_win) begin
                    state_d     = WAIT;
                    mem_req_d   = 1'b1;
                    owner_d     = ls_win ? OWN_LS : OWN_IF;
                    mem_we_d    = ls_win && i_ls_we;
                    mem_addr_d  = ls_win ? i_ls_addr : i_if_addr;
                    mem_wdata_d = ls_win ? i_ls_wdata : 32'h0;
                    mem_be_d    = ls_win ? i_ls_be : BE_WORD;
                end
            end
            WAIT: begin
                if (done) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    err_d     = !i_mem_ack;
                    if (owner_q == OWN_LS) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = rsp_data;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = rsp_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            err_q       <= err_d;
        end
    end

    assign o_if_gnt    = if_win;
    assign o_ls_gnt    = ls_win;
    assign o_if_rvalid = if_rvalid_q;
    assign o_ls_rvalid = ls_rvalid_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_ls_rdata  = ls_rdata_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_be    = mem_be_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration table plus
// hand sequences for fetch, store, timeout, reset and back-to-back.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_MAX (4),
        .TIMEOUT    (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_gnt    (if_gnt),
        .o_if_rvalid (if_rvalid),
        .o_if_rdata  (if_rdata),
        .i_ls_req    (ls_req),
        .i_ls_we     (ls_we),
        .i_ls_addr   (ls_addr),
        .i_ls_wdata  (ls_wdata),
        .i_ls_be     (ls_be),
        .o_ls_gnt    (ls_gnt),
        .o_ls_rvalid (ls_rvalid),
        .o_ls_rdata  (ls_rdata),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_be    (mem_be),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata),
        .o_err       (err)
    );

    typedef struct {
        logic        if_req;
        logic        ls_req;
        logic        ack;
        logic [31:0] rdata;
        logic        e_if_gnt;
        logic        e_ls_gnt;
        logic        e_if_rv;
        logic        e_ls_rv;
        logic        e_mreq;
        logic [31:0] e_if_rd;
        logic [31:0] e_ls_rd;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " if_gnt"}, if_gnt, 0);
        chk({tag, " ls_gnt"}, ls_gnt, 0);
        chk({tag, " if_rvalid"}, if_rvalid, 0);
        chk({tag, " ls_rvalid"}, ls_rvalid, 0);
        chk({tag, " if_rdata"}, if_rdata, 0);
        chk({tag, " ls_rdata"}, ls_rdata, 0);
        chk({tag, " mem_req"}, mem_req, 0);
        chk({tag, " mem_we"}, mem_we, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
        chk({tag, " mem_be"}, mem_be, 0);
        chk({tag, " err"}, err, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 0; if_addr = 32'h0000_0040;
        ls_req = 0; ls_we = 0; ls_addr = 32'h0000_1000;
        ls_wdata = 0; ls_be = 4'hF;
        mem_ack = 0; mem_rdata = 0;

        // LS,LS,LS,LS,IF,LS under contention with immediate acks
        tbl[0]  = '{1,1,0,32'h00, 0,1,0,0,0, 32'h00,32'h00};
        tbl[1]  = '{1,1,1,32'h11, 0,0,0,0,1, 32'h00,32'h00};
        tbl[2]  = '{1,1,0,32'h00, 0,1,0,1,0, 32'h00,32'h11};
        tbl[3]  = '{1,1,1,32'h33, 0,0,0,0,1, 32'h00,32'h11};
        tbl[4]  = '{1,1,0,32'h00, 0,1,0,1,0, 32'h00,32'h33};
        tbl[5]  = '{1,1,1,32'h55, 0,0,0,0,1, 32'h00,32'h33};
        tbl[6]  = '{1,1,0,32'h00, 0,1,0,1,0, 32'h00,32'h55};
        tbl[7]  = '{1,1,1,32'h77, 0,0,0,0,1, 32'h00,32'h55};
        tbl[8]  = '{1,1,0,32'h00, 1,0,0,1,0, 32'h00,32'h77};
        tbl[9]  = '{1,1,1,32'h99, 0,0,0,0,1, 32'h00,32'h77};
        tbl[10] = '{1,1,0,32'h00, 0,1,1,0,0, 32'h99,32'h77};
        tbl[11] = '{0,0,1,32'hBB, 0,0,0,0,1, 32'h99,32'h77};
        tbl[12] = '{0,0,1,32'hCC, 0,0,0,1,0, 32'h99,32'hBB};
        tbl[13] = '{0,0,0,32'h00, 0,0,0,0,0, 32'h99,32'hBB};

        // Reset state, with requests present to check grant gating
        repeat (3) @(posedge clk);
        #2;
        if_req = 1; ls_req = 1;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        if_req = 0; ls_req = 0;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            tick();
            if_req    = tbl[i].if_req;
            ls_req    = tbl[i].ls_req;
            mem_ack   = tbl[i].ack;
            mem_rdata = tbl[i].rdata;
            #1;
            chk($sformatf("tbl%0d if_gnt", i), if_gnt, tbl[i].e_if_gnt);
            chk($sformatf("tbl%0d ls_gnt", i), ls_gnt, tbl[i].e_ls_gnt);
            chk($sformatf("tbl%0d if_rv", i), if_rvalid, tbl[i].e_if_rv);
            chk($sformatf("tbl%0d ls_rv", i), ls_rvalid, tbl[i].e_ls_rv);
            chk($sformatf("tbl%0d mem_req", i), mem_req, tbl[i].e_mreq);
            chk($sformatf("tbl%0d if_rd", i), if_rdata, tbl[i].e_if_rd);
            chk($sformatf("tbl%0d ls_rd", i), ls_rdata, tbl[i].e_ls_rd);
        end

        // IF only, ack on the third WAIT cycle
        tick();
        mem_ack = 0; if_req = 1; if_addr = 32'h0000_0010;
        #1;
        chk("if gnt", if_gnt, 1);
        tick();
        if_req = 0;
        #1;
        chk("if gnt pulse", if_gnt, 0);
        chk("if mem_req", mem_req, 1);
        chk("if mem_addr", mem_addr, 32'h10);
        chk("if mem_be", mem_be, 4'hF);
        chk("if mem_we", mem_we, 0);
        tick();
        tick();
        mem_ack = 1; mem_rdata = 32'h0050_0093;
        #1;
        chk("if no early rv", if_rvalid, 0);
        tick();
        mem_ack = 0;
        #1;
        chk("if rvalid", if_rvalid, 1);
        chk("if rdata", if_rdata, 32'h0050_0093);
        chk("if mem_req drop", mem_req, 0);
        tick();
        chk("if rv pulse", if_rvalid, 0);

        // Store: fields held through WAIT, rdata reads back 0
        ls_req = 1; ls_we = 1; ls_addr = 32'h7000;
        ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b0011;
        #1;
        chk("st gnt", ls_gnt, 1);
        for (int k = 0; k < 2; k++) begin
            tick();
            ls_req = 0; ls_we = 0; ls_wdata = 0; ls_be = 4'hF;
            mem_ack = (k == 1); mem_rdata = 32'h1234_5678;
            #1;
            chk("st mem_we", mem_we, 1);
            chk("st mem_addr", mem_addr, 32'h7000);
            chk("st mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("st mem_be", mem_be, 4'b0011);
        end
        tick();
        mem_ack = 0;
        #1;
        chk("st rvalid", ls_rvalid, 1);
        chk("st rdata", ls_rdata, 0);
        chk("st err", err, 0);

        // Timeout: rvalid+err 8 cycles after the grant edge
        tick();
        ls_req = 1; ls_addr = 32'h300;
        #1;
        chk("to gnt", ls_gnt, 1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            ls_req = 0;
            #1;
            chk($sformatf("to rv k%0d", k), ls_rvalid, (k == 9));
            chk($sformatf("to err k%0d", k), err, (k == 9));
        end
        chk("to rdata", ls_rdata, 0);
        chk("to mem_req", mem_req, 0);
        tick();
        mem_ack = 1; mem_rdata = 32'hFFFF_0000;
        tick();
        mem_ack = 0;
        #1;
        chk("late ack rv", ls_rvalid, 0);
        chk("late ack err", err, 0);
        chk("late ack rdata", ls_rdata, 0);

        // Ack in the terminal-count cycle completes normally
        tick();
        ls_req = 1;
        #1;
        chk("tc gnt", ls_gnt, 1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            ls_req = 0;
            mem_ack = (k == 8); mem_rdata = 32'hA5A5_5A5A;
            #1;
            chk($sformatf("tc rv k%0d", k), ls_rvalid, (k == 9));
            chk($sformatf("tc err k%0d", k), err, 0);
        end
        chk("tc rdata", ls_rdata, 32'hA5A5_5A5A);

        // Back-to-back: IF granted in the LS rvalid cycle
        tick();
        mem_ack = 0; ls_req = 1; ls_addr = 32'h200;
        #1;
        chk("b2b ls gnt", ls_gnt, 1);
        tick();
        ls_req = 0; if_req = 1; if_addr = 32'h44;
        mem_ack = 1; mem_rdata = 32'h0000_CAFE;
        #1;
        chk("b2b wait gnt", if_gnt, 0);
        tick();
        mem_ack = 0;
        #1;
        chk("b2b ls rv", ls_rvalid, 1);
        chk("b2b ls rd", ls_rdata, 32'h0000_CAFE);
        chk("b2b if gnt", if_gnt, 1);
        chk("b2b ls gnt0", ls_gnt, 0);
        tick();
        if_req = 0; mem_ack = 1; mem_rdata = 32'h13;
        #1;
        chk("b2b if addr", mem_addr, 32'h44);
        chk("b2b if be", mem_be, 4'hF);
        tick();
        mem_ack = 0;
        #1;
        chk("b2b if rv", if_rvalid, 1);
        chk("b2b if rd", if_rdata, 32'h13);

        // Reset mid-WAIT clears everything asynchronously
        tick();
        if_req = 1; if_addr = 32'h80;
        #1;
        chk("rst gnt", if_gnt, 1);
        tick();
        chk("rst pre mem_req", mem_req, 1);
        rst_n = 0;
        #1;
        chk_all_zero("mid-rst");
        @(negedge clk);
        rst_n = 1; if_req = 0; mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_ack = 0;
        tick();
        chk("post-rst if rv", if_rvalid, 0);
        chk("post-rst ls rv", ls_rvalid, 0);
        chk("post-rst if rd", if_rdata, 0);
        if_req = 1; if_addr = 32'h84;
        #1;
        chk("post-rst gnt", if_gnt, 1);
        tick();
        if_req = 0; mem_ack = 1; mem_rdata = 32'h0000_0777;
        #1;
        chk("post-rst addr", mem_addr, 32'h84);
        tick();
        mem_ack = 0;
        #1;
        chk("post-rst rv", if_rvalid, 1);
        chk("post-rst rd", if_rdata, 32'h0000_0777);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
